// File: rtl/mem_stage.sv
// mem_stage: consumer end of the EX/MEM pipeline register.
//
// Turns the EX/MEM control/data into a dcache request. Waits for dhit,
// implements LL/SC with a single link register that snoop invalidates clear,
// and presents the writeback word plus control to the MEM/WB register.
// mem_stall is high while a data access is outstanding.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   *_out                EX/MEM outputs (address/ALU result, store data,
//                        pc+4, dest reg, control bits)
//   advance              MEM/WB write enable this cycle
//   dhit, dmemload       dcache completion and load data
//   snoop_inv/addr       coherence invalidate and its address
//   dmemREN/WEN/addr/store  dcache request
//   wdat_in, regWEN_in, Halt_in, writeReg_in, pcplus4_in  to MEM/WB
//   mem_stall            access outstanding
module mem_stage #(
  parameter int WORD_W  = 32,
  parameter bit LINK_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] aluOutport_out,
  input  logic [WORD_W-1:0] rdat2_out,
  input  logic [WORD_W-1:0] pcplus4_out,
  input  logic [4:0]        writeReg_out,
  input  logic              MemToReg_out,
  input  logic              regWEN_out,
  input  logic              dMemREN_out,
  input  logic              dMemWEN_out,
  input  logic              Atomic_out,
  input  logic              Halt_out,
  input  logic              advance,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] wdat_in,
  output logic              regWEN_in,
  output logic              Halt_in,
  output logic [4:0]        writeReg_in,
  output logic [WORD_W-1:0] pcplus4_in,
  output logic              mem_stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                link_valid_q, link_valid_d;
  logic [WORD_W-1:2]   link_addr_q, link_addr_d;
  logic [WORD_W-1:0]   hold_data_q, hold_data_d;

  logic                req, sc_instr, sc, ll, link_hit, snoop_clear;
  logic                sc_ok, sc_fail, issue, done;
  logic [WORD_W-1:0]   result;

  // Byte offsets never take part in word-granular link comparisons.
  logic                unused_offset;
  assign unused_offset = ^snoop_addr[1:0];

  always_comb begin
    req         = dMemREN_out | dMemWEN_out;
    sc_instr    = Atomic_out & dMemWEN_out;
    sc          = LINK_EN & sc_instr;
    ll          = LINK_EN & Atomic_out & dMemREN_out;
    link_hit    = (link_addr_q == aluOutport_out[WORD_W-1:2]);
    snoop_clear = snoop_inv & (snoop_addr[WORD_W-1:2] == link_addr_q);
    // A snoop landing in the same cycle as the SC evaluation kills it.
    sc_ok       = link_valid_q & link_hit & ~snoop_clear;
    sc_fail     = (state_q == S_IDLE) & sc & ~sc_ok;
    // Requests are gated by nRST so they drop the instant reset asserts,
    // even though EX/MEM may still be presenting a memory op.
    issue       = nRST & (((state_q == S_IDLE) & req & ~sc_fail) |
                          (state_q == S_WAIT));
    done        = issue & dhit;
  end

  // Live result. A store-conditional that reaches WAIT was issued, so it
  // reports success; with LINK_EN=0 sc_fail is never set and SC returns 1.
  always_comb begin
    result = aluOutport_out;
    if (sc_instr) begin
      result    = '0;
      result[0] = ~sc_fail;
    end else if (MemToReg_out) begin
      result = dmemload;
    end
  end

  always_comb begin
    dmemREN     = issue & dMemREN_out;
    dmemWEN     = issue & dMemWEN_out;
    dmemaddr    = issue ? aluOutport_out : '0;
    dmemstore   = issue ? rdat2_out : '0;
    mem_stall   = issue & ~dhit;
    wdat_in     = ((state_q == S_HOLD) && (sc_instr || MemToReg_out)) ?
                  hold_data_q : result;
    regWEN_in   = regWEN_out & ~mem_stall;
    Halt_in     = Halt_out;
    writeReg_in = writeReg_out;
    pcplus4_in  = pcplus4_out;
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    case (state_q)
      S_IDLE: begin
        if (sc_fail || (req && dhit)) begin
          hold_data_d = result;
          state_d     = advance ? S_IDLE : S_HOLD;
        end else if (req) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dhit) begin
          hold_data_d = result;
          state_d     = advance ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (advance) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (snoop_clear) link_valid_d = 1'b0;
    if (sc && (done || sc_fail)) link_valid_d = 1'b0;
    if (dMemWEN_out && !sc && done && link_hit) link_valid_d = 1'b0;
    if (Halt_out) link_valid_d = 1'b0;
    // LL completion wins over a concurrent snoop.
    if (ll && done) begin
      link_valid_d = 1'b1;
      link_addr_d  = aluOutport_out[WORD_W-1:2];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, reset corner sequences and
// randomized operations checked against a transaction-level model.
module tb_mem_stage;

  typedef enum logic [2:0] {OP_ALU, OP_LW, OP_SW, OP_LL, OP_SC} op_t;

  typedef struct {
    op_t         op;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    int          hold;
    bit          snp;
    logic [31:0] snaddr;
    bit          halt;
    bit          exp_issue;
    logic [31:0] exp_wdat;
  } vec_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] aluOutport_out, rdat2_out, pcplus4_out, dmemload, snoop_addr;
  logic [4:0]  writeReg_out;
  logic        MemToReg_out, regWEN_out, dMemREN_out, dMemWEN_out;
  logic        Atomic_out, Halt_out, advance, dhit, snoop_inv;
  logic        dmemREN, dmemWEN, regWEN_in, Halt_in, mem_stall;
  logic [31:0] dmemaddr, dmemstore, wdat_in, pcplus4_in;
  logic [4:0]  writeReg_in;

  int total  = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  mem_stage #(.WORD_W(32), .LINK_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST),
    .aluOutport_out(aluOutport_out), .rdat2_out(rdat2_out),
    .pcplus4_out(pcplus4_out), .writeReg_out(writeReg_out),
    .MemToReg_out(MemToReg_out), .regWEN_out(regWEN_out),
    .dMemREN_out(dMemREN_out), .dMemWEN_out(dMemWEN_out),
    .Atomic_out(Atomic_out), .Halt_out(Halt_out),
    .advance(advance), .dhit(dhit), .dmemload(dmemload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .wdat_in(wdat_in), .regWEN_in(regWEN_in),
    .Halt_in(Halt_in), .writeReg_in(writeReg_in), .pcplus4_in(pcplus4_in),
    .mem_stall(mem_stall)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic clear_inputs();
    aluOutport_out = '0; rdat2_out = '0; pcplus4_out = '0; writeReg_out = '0;
    MemToReg_out = 0; regWEN_out = 0; dMemREN_out = 0; dMemWEN_out = 0;
    Atomic_out = 0; Halt_out = 0; advance = 1; dhit = 0; dmemload = '0;
    snoop_inv = 0; snoop_addr = '0;
  endtask

  // Present one instruction, complete it after lat wait cycles, then hold
  // it in MEM/WB for 'hold' extra cycles with advance low.
  task automatic run_op(input op_t op, input logic [31:0] addr,
                        input logic [31:0] data, input int lat, input int hold,
                        input bit snp, input logic [31:0] snaddr,
                        input bit halt, input bit exp_issue,
                        input logic [31:0] exp_wdat, input string tag);
    bit   active;
    int   nact;
    logic stall_e;
    @(negedge CLK);
    aluOutport_out = addr;
    rdat2_out      = data;
    pcplus4_out    = addr + 32'd4;
    writeReg_out   = addr[6:2];
    dMemREN_out    = (op == OP_LW) || (op == OP_LL);
    dMemWEN_out    = (op == OP_SW) || (op == OP_SC);
    Atomic_out     = (op == OP_LL) || (op == OP_SC);
    MemToReg_out   = dMemREN_out;
    regWEN_out     = (op != OP_SW);
    Halt_out       = halt;
    active = (op != OP_ALU) && exp_issue;
    nact   = active ? lat + 1 : 1;
    for (int i = 0; i < nact; i++) begin
      if (i > 0) @(negedge CLK);
      snoop_inv  = snp && (i == 0);
      snoop_addr = snaddr;
      dhit       = active && (i == lat);
      dmemload   = dhit ? data : $urandom;
      advance    = (i == nact - 1) && (hold == 0);
      #4;
      stall_e = active && (i < lat);
      chk({tag, " ren"}, dmemREN, active && dMemREN_out);
      chk({tag, " wen"}, dmemWEN, active && dMemWEN_out);
      chk({tag, " stall"}, mem_stall, stall_e);
      chk({tag, " regwen"}, regWEN_in, regWEN_out && !stall_e);
      chk({tag, " halt"}, Halt_in, halt);
      chk({tag, " pc4"}, pcplus4_in, addr + 32'd4);
      if (active) chk({tag, " addr"}, dmemaddr, addr);
      if (active && dMemWEN_out) chk({tag, " store"}, dmemstore, data);
      if (i == nact - 1) chk({tag, " wdat"}, wdat_in, exp_wdat);
    end
    for (int j = 0; j < hold; j++) begin
      @(negedge CLK);
      snoop_inv = 0;
      dhit      = 0;
      dmemload  = $urandom;
      advance   = (j == hold - 1);
      #4;
      chk({tag, " hold ren"}, dmemREN, 1'b0);
      chk({tag, " hold wen"}, dmemWEN, 1'b0);
      chk({tag, " hold stall"}, mem_stall, 1'b0);
      chk({tag, " hold wdat"}, wdat_in, exp_wdat);
    end
  endtask

  vec_t        tbl[25];
  logic [31:0] addrs[6];

  initial begin
    tbl[0]  = '{OP_LW,  32'h100, 32'hDEADBEEF, 3, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF};
    tbl[1]  = '{OP_SW,  32'h200, 32'h00001234, 0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000200};
    tbl[2]  = '{OP_LW,  32'h104, 32'hCAFE0001, 0, 2, 1'b0, 32'h0,   1'b0, 1'b1, 32'hCAFE0001};
    tbl[3]  = '{OP_LW,  32'h108, 32'h0A0B0C0D, 2, 1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0A0B0C0D};
    tbl[4]  = '{OP_LL,  32'h300, 32'h00000055, 1, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000055};
    tbl[5]  = '{OP_SC,  32'h300, 32'h0000AAAA, 0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000001};
    tbl[6]  = '{OP_SC,  32'h300, 32'h0000BBBB, 0, 0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00000000};
    tbl[7]  = '{OP_LL,  32'h300, 32'h00000007, 0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000007};
    tbl[8]  = '{OP_ALU, 32'h099, 32'h0,        0, 0, 1'b1, 32'h302, 1'b0, 1'b0, 32'h00000099};
    tbl[9]  = '{OP_SC,  32'h300, 32'h0000CCCC, 0, 0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00000000};
    tbl[10] = '{OP_LL,  32'h300, 32'h00000009, 2, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000009};
    tbl[11] = '{OP_ALU, 32'hABC, 32'h0,        0, 0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h00000ABC};
    tbl[12] = '{OP_SC,  32'h300, 32'h0000DDDD, 2, 1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000001};
    tbl[13] = '{OP_LL,  32'h300, 32'h00000011, 0, 0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h00000011};
    tbl[14] = '{OP_SC,  32'h300, 32'h0000EEEE, 0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000001};
    tbl[15] = '{OP_LL,  32'h304, 32'h00000022, 0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000022};
    tbl[16] = '{OP_SC,  32'h304, 32'h0000FFFF, 0, 0, 1'b1, 32'h304, 1'b0, 1'b0, 32'h00000000};
    tbl[17] = '{OP_LL,  32'h304, 32'h00000033, 0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000033};
    tbl[18] = '{OP_SW,  32'h306, 32'h00000044, 1, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000306};
    tbl[19] = '{OP_SC,  32'h304, 32'h00000000, 0, 0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00000000};
    tbl[20] = '{OP_LL,  32'h300, 32'h00000055, 0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000055};
    tbl[21] = '{OP_ALU, 32'h000, 32'h0,        0, 0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h00000000};
    tbl[22] = '{OP_SC,  32'h300, 32'h00000066, 0, 0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00000000};
    tbl[23] = '{OP_SC,  32'h300, 32'h00000077, 0, 2, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00000000};
    tbl[24] = '{OP_LL,  32'h300, 32'h00000077, 0, 0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00000077};
    addrs = '{32'h100, 32'h104, 32'h300, 32'h302, 32'h304, 32'h400};

    // Reset state, with a load request present on the EX/MEM side.
    clear_inputs();
    nRST           = 1'b0;
    dMemREN_out    = 1'b1;
    aluOutport_out = 32'h100;
    #12;
    chk("reset ren", dmemREN, 1'b0);
    chk("reset wen", dmemWEN, 1'b0);
    chk("reset stall", mem_stall, 1'b0);
    chk("reset addr", dmemaddr, 32'h0);
    @(negedge CLK);
    clear_inputs();
    nRST = 1'b1;

    for (int k = 0; k < 25; k++)
      run_op(tbl[k].op, tbl[k].addr, tbl[k].data, tbl[k].lat, tbl[k].hold,
             tbl[k].snp, tbl[k].snaddr, tbl[k].halt, tbl[k].exp_issue,
             tbl[k].exp_wdat, $sformatf("vec%0d", k));

    // Reset asserted while a load sits in WAIT, with the link set above.
    @(negedge CLK);
    aluOutport_out = 32'h100; dMemREN_out = 1; MemToReg_out = 1;
    regWEN_out = 1; dhit = 0; advance = 0; snoop_inv = 0; Halt_out = 0;
    Atomic_out = 0; dMemWEN_out = 0;
    #4;
    chk("wrst c0 stall", mem_stall, 1'b1);
    @(negedge CLK);
    #4;
    chk("wrst c1 stall", mem_stall, 1'b1);
    chk("wrst c1 ren", dmemREN, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    chk("wrst async ren", dmemREN, 1'b0);
    chk("wrst async wen", dmemWEN, 1'b0);
    chk("wrst async stall", mem_stall, 1'b0);
    @(negedge CLK);
    clear_inputs();
    nRST = 1'b1;
    run_op(OP_SC, 32'h300, 32'h0000ABCD, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0,
           32'h0, "sc after reset");

    // Randomized operations against a transaction-level model.
    begin
      bit          m_lv;
      logic [31:0] m_la;
      m_lv = 1'b0;
      m_la = '0;
      for (int k = 0; k < 200; k++) begin
        op_t         op;
        logic [31:0] addr, data, snaddr, wd;
        int          lat, hold;
        bit          snp, halt, issue, sclr, same;
        op     = op_t'($urandom_range(0, 4));
        addr   = addrs[$urandom_range(0, 5)];
        data   = $urandom;
        lat    = $urandom_range(0, 3);
        hold   = $urandom_range(0, 2);
        snp    = ($urandom_range(0, 3) == 0);
        snaddr = addrs[$urandom_range(0, 5)];
        halt   = (op == OP_ALU) && ($urandom_range(0, 4) == 0);
        same   = (addr[31:2] == m_la[31:2]);
        sclr   = snp && m_lv && (snaddr[31:2] == m_la[31:2]);
        issue  = 1'b1;
        case (op)
          OP_ALU:  begin issue = 1'b0; wd = addr; end
          OP_LW:   wd = data;
          OP_LL:   wd = data;
          OP_SW:   wd = addr;
          default: begin
            issue = m_lv && same && !sclr;
            wd    = {31'b0, issue};
          end
        endcase
        if (sclr) m_lv = 1'b0;
        if (op == OP_SC) m_lv = 1'b0;
        if (op == OP_SW && same) m_lv = 1'b0;
        if (op == OP_LL) begin m_lv = 1'b1; m_la = addr; end
        if (halt) m_lv = 1'b0;
        run_op(op, addr, data, lat, hold, snp, snaddr, halt, issue, wd,
               $sformatf("rnd%0d", k));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
